// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage front end for a word-wide big-endian data memory.
//            Performs lane alignment, load extension and sub-word RMW stores.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int MEM_LATENCY = 2,
   parameter int MEM_BYTES   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_memread,
   output logic        mem_memwrite,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0]  C_SIZE_BYTE = 2'b00;
   localparam logic [1:0]  C_SIZE_HALF = 2'b01;
   localparam logic [1:0]  C_SIZE_WORD = 2'b10;
   localparam logic [1:0]  C_SIZE_RSVD = 2'b11;
   localparam logic [3:0]  C_CNT_INIT  = 4'(MEM_LATENCY - 1);
   localparam logic [32:0] C_MEM_BYTES = 33'(MEM_BYTES);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [1:0]  r_off;
   logic [15:0] r_wdata;

   logic [2:0]  w_bytes;
   logic [32:0] w_end;
   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   assign req_ready = (r_state == IDLE);

   // Range check uses a 33-bit sum so addresses near 2^32 cannot wrap into range.
   always_comb begin
      w_bytes = 3'd4;
      case (req_size)
         C_SIZE_BYTE: w_bytes = 3'd1;
         C_SIZE_HALF: w_bytes = 3'd2;
         default:     w_bytes = 3'd4;
      endcase
      w_end = {1'b0, req_addr} + {30'd0, w_bytes};
      w_err = (req_size == C_SIZE_RSVD)
            | ((req_size == C_SIZE_HALF) & req_addr[0])
            | ((req_size == C_SIZE_WORD) & (req_addr[1:0] != 2'b00))
            | (w_end > C_MEM_BYTES);
   end

   always_comb begin
      w_byte = 8'd0;
      case (r_off)
         2'd0: w_byte = mem_read_data[31:24];
         2'd1: w_byte = mem_read_data[23:16];
         2'd2: w_byte = mem_read_data[15:8];
         2'd3: w_byte = mem_read_data[7:0];
      endcase
      w_half = r_off[1] ? mem_read_data[15:0] : mem_read_data[31:16];
      case (r_size)
         C_SIZE_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
         C_SIZE_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
         default:     w_load_data = mem_read_data;
      endcase
   end

   // Merge store data into the word fetched during READ, keeping other lanes.
   always_comb begin
      w_merged = mem_read_data;
      if (r_size == C_SIZE_BYTE) begin
         case (r_off)
            2'd0: w_merged[31:24] = r_wdata[7:0];
            2'd1: w_merged[23:16] = r_wdata[7:0];
            2'd2: w_merged[15:8]  = r_wdata[7:0];
            2'd3: w_merged[7:0]   = r_wdata[7:0];
         endcase
      end else if (r_off[1]) begin
         w_merged[15:0] = r_wdata;
      end else begin
         w_merged[31:16] = r_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_cnt          <= 4'd0;
         r_write        <= 1'b0;
         r_size         <= 2'b00;
         r_signed       <= 1'b0;
         r_off          <= 2'b00;
         r_wdata        <= 16'd0;
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= 32'd0;
         mem_address    <= 32'd0;
         mem_write_data <= 32'd0;
         mem_memread    <= 1'b0;
         mem_memwrite   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write  <= req_write;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_off    <= req_addr[1:0];
                  r_wdata  <= req_wdata[15:0];
                  if (w_err) begin
                     r_state    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else if (req_write && (req_size == C_SIZE_WORD)) begin
                     r_state        <= WRITE;
                     mem_address    <= {req_addr[31:2], 2'b00};
                     mem_write_data <= req_wdata;
                     mem_memwrite   <= 1'b1;
                  end else begin
                     r_state     <= READ;
                     mem_address <= {req_addr[31:2], 2'b00};
                     mem_memread <= 1'b1;
                     r_cnt       <= C_CNT_INIT;
                  end
               end
            end
            READ: begin
               if (r_cnt == 4'd0) begin
                  mem_memread <= 1'b0;
                  if (r_write) begin
                     r_state        <= WRITE;
                     mem_write_data <= w_merged;
                     mem_memwrite   <= 1'b1;
                  end else begin
                     r_state    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= w_load_data;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            WRITE: begin
               mem_memwrite <= 1'b0;
               r_state      <= RESP;
               resp_valid   <= 1'b1;
               resp_err     <= 1'b0;
               resp_rdata   <= 32'd0;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side front end for the word-wide, big-endian data memory. Accepts one load or store per handshake from the MEM stage and handles byte, halfword and word sizes. Aligns and sign- or zero-extends load data, and performs read-modify-write for sub-word stores because the memory only writes whole words. Traps misaligned and out-of-range accesses before they reach memory.

## Interface
- MEM_LATENCY, 2, cycles from `mem_memread` and `mem_address` valid to `mem_read_data` valid; legal range is 1 to 15.
- MEM_BYTES, 32, memory size in bytes; must be a multiple of 4.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; equals state==IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- req_signed  input  1  sign-extend loads; ignored for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  qualifies `resp_valid`; the access was rejected.
- mem_address  output  32  word-aligned address (`req_addr & ~3`).
- mem_write_data  output  32  full word to write.
- mem_memread  output  1  memory read strobe.
- mem_memwrite  output  1  memory write strobe.
- mem_read_data  input  32  big-endian word: byte at offset 0 is bits [31:24].

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request fields are captured into internal registers on `req_valid & req_ready`.
- **Error check at capture.** An error is any of:
  - `req_size==11`;
  - a halfword with `addr[0]=1`;
  - a word with `addr[1:0]!=0`;
  - `addr + bytes > MEM_BYTES`.
- On error the unit goes IDLE→RESP with `resp_err=1` and `resp_rdata=0`. No memory strobe is ever asserted for an errored request.
- **Load.** IDLE→READ. After MEM_LATENCY cycles the unit captures `mem_read_data` and goes to RESP.
  - Lane select by offset: byte k is bits [31-8k -: 8]; half at offset 0 is [31:16], at offset 2 is [15:0].
  - The selected lane is zero- or sign-extended to 32 bits per `req_signed`.
- **Word store.** IDLE→WRITE→RESP; `mem_write_data = req_wdata`.
- **Byte or half store.** IDLE→READ for MEM_LATENCY cycles, then WRITE, then RESP.
  - The captured word is merged with `req_wdata[7:0]` or `req_wdata[15:0]` at the lane.
  - All other bytes are preserved.
- **RESP.** `resp_valid=1` for exactly one cycle, then the unit returns to IDLE. There is no response back-pressure.
- An internal down-counter times READ; it loads MEM_LATENCY-1 on entry.
- **Reset**, asynchronous and usable at any time including mid-operation:
  - state goes to IDLE and the counter is cleared;
  - `resp_valid`, `resp_err`, `mem_memread` and `mem_memwrite` go to 0;
  - `resp_rdata`, `mem_address` and `mem_write_data` go to 0;
  - a store in progress is abandoned and no write is issued;
  - `req_ready` is 1 from the first edge after `rst_n` rises.

## Timing
- Cycle 0 is the handshake edge.
- `mem_memread` is high for exactly the MEM_LATENCY READ cycles, with `mem_address` stable throughout.
- `mem_memwrite` is high for exactly one cycle (WRITE), with `mem_address` and `mem_write_data` stable in that cycle.
- Load latency is MEM_LATENCY+1 cycles: `resp_valid` is asserted in cycle MEM_LATENCY+1.
- Word store: WRITE in cycle 1, `resp_valid` in cycle 2.
- Sub-word store: READ in cycles 1..L, WRITE in cycle L+1, `resp_valid` in cycle L+2.
- Error: `resp_valid` in cycle 1.
- `mem_memread` and `mem_memwrite` are never high in the same cycle.
- A new request can be accepted in the cycle after RESP, when state is IDLE again.
- `req_valid` while not ready is ignored. The requester must hold the request until it is accepted.

## Test plan
- Memory model with L=2 and word 0x10 = 0x8899AABB. Signed byte load at 0x11 → `resp_rdata=0xFFFFFF99` in cycle 3, with `mem_memread` high in cycles 1-2 and `mem_address=0x10`.
- Unsigned half load at 0x12 → `0x0000AABB`. Signed half load at 0x10 → `0xFFFF8899`.
- Byte store of 0x5A at 0x13 → `mem_memwrite` only in cycle 3 with `mem_write_data=0x8899AA5A`, and `resp_valid` in cycle 4. A following word load at 0x10 returns `0x8899AA5A`.
- Word store of 0x12345678 at 0x1C → no read, write in cycle 1, response in cycle 2. A word store at 0x1E, or a word load at 0x1D/0x20, → `resp_err=1` in cycle 1 with no strobes.
- Reserved size 11 → error. A half store at 0x1F → error (misaligned and out-of-range).
- Drop `rst_n` during READ of a sub-word store → strobes fall immediately, `mem_memwrite` is never asserted, memory is unchanged, and `req_ready=1` after release.
